uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1 framing (1 start, 8 data LSB-first, 1 stop), line idle high.
- Samples an asynchronous serial line with the system clock, reassembles each byte and presents it on a parallel bus with a one-cycle valid strobe.
- Sits between the board-level RX pin and the byte-consuming logic of the pipeline.

Parameters:
- CLKS_PER_BIT, 860, system clocks per serial bit. At a 10 ns clock this gives a 8600 ns bit period, about 116 kbaud. Must be ≥ 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8 for this release.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- serialInput  input  1  asynchronous serial RX line, idle high.
- dataOut  output  8  last correctly received byte; holds between frames.
- dataValid  output  1  one-cycle pulse when dataOut is updated.
- frameError  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high from accepted start edge until return to IDLE.

Behaviour:
- Reset values: dataOut=8'h00, dataValid=0, frameError=0, busy=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: 2-FF chain on serialInput. All decisions use the synchronized value `rx_s`, which adds 2 cycles of latency.
- Counters:
  - `clk_cnt` is sized to hold CLKS_PER_BIT-1.
  - `bit_idx` is 3 bits.
- IDLE:
  - Wait for `rx_s`=0.
  - On detection go to START, clear `clk_cnt`, set busy=1.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (integer division), then re-sample the line at mid start bit.
  - Low: clear `clk_cnt` and `bit_idx`, go to DATA.
  - High: treat as a glitch. Return to IDLE with busy=0 and no strobes.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample `rx_s` into shift register position `bit_idx` (bit 0 first).
  - After `bit_idx`=7 is sampled, go to STOP. Otherwise increment `bit_idx`.
- STOP:
  - After CLKS_PER_BIT-1 counts, sample the line at mid stop bit.
  - 1: load dataOut from the shift register and pulse dataValid for exactly one cycle, then go to IDLE.
  - 0: pulse frameError for one cycle with dataOut unchanged, then go to BREAK_WAIT.
- BREAK_WAIT:
  - Stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from re-triggering.
  - busy stays 1 in this state.
- Back-to-back frames: because STOP exits at mid stop bit, a start edge that follows the stop bit immediately is caught. No idle gap is required.
- dataValid and frameError are mutually exclusive and never asserted for more than one cycle.
- Reset asserted mid-frame: immediately return to reset values. The partial byte is discarded and no strobe is issued.
- Latency: dataValid rises about 9.5 bit periods plus 2–3 clocks after the start-bit falling edge on serialInput.
- Tolerance: correct reception for baud mismatch within ±3 %.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK_WAIT.
  - Constant DATA_BITS=8.
  - Localparam helper for the half-bit count.
- One natural sub-module, `sync_2ff`: the generic 2-flop synchronizer, reset value parameterizable (1 here).
- FSM, counters and shift register stay in `uart_rx`.

Test Plan:
- Reset: hold rst_n=0 with serialInput=1 for 10 cycles, release -> dataOut=8'h00, dataValid=0, frameError=0, busy=0.
- Single byte: one clock after the first rising clk edge, transmit 8'hAF at 8600 ns/bit (line 0, then 1,1,1,1,0,1,0,1, then 1) -> exactly one dataValid pulse about mid stop bit, dataOut=8'hAF, frameError never asserted.
- Back-to-back: transmit 8'h55 then 8'h00 with no idle gap -> two dataValid pulses, dataOut=8'h55 then 8'h00, busy low only briefly between frames.
- Framing error: transmit 8'h3C with the stop bit driven 0, then line 1 -> frameError pulses once, no dataValid, dataOut keeps its previous value, FSM returns to IDLE once the line is high.
- Glitch rejection: drive serialInput low for 2000 ns (shorter than half a bit), then high -> FSM returns to IDLE with no strobe; a following 8'hC3 frame is received correctly.
- Reset mid-frame: assert rst_n during data bit 4 of 8'hF0, release, send 8'h12 -> no strobe for the aborted frame, dataOut=8'h12 after the second frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM states, frame width and
// the bit-timing helper used to locate the middle of the start bit.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_state_e;

  // Last counter value of the half-bit wait that lands on mid start bit.
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level; the reset
// value is a parameter so an idle-high line does not look active after reset.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the RX pin, times each bit from the start
// edge and presents every good byte on dataOut with a one-cycle strobe.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 860
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serialInput,
  output logic [7:0]        dataOut,
  output logic              dataValid,
  output logic              frameError,
  output logic              busy,
  output uart_state_e       state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (serialInput),
    .sync_o  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  // dataValid is a pure strobe: there is no ready, the consumer must take
  // dataOut on the cycle dataValid is high (dataOut then holds until the next).
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          if (!rx_s) begin
            state_d   = DATA;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      BREAK_WAIT: begin
        if (rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign dataOut    = data_q;
  assign dataValid  = valid_q;
  assign frameError = ferr_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames at 8600 ns/bit, expected bytes in
// a queue consumed on each dataValid, per-scenario checks on strobe counts.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLKS_PER_BIT = 860;
  localparam int BIT_NS       = 8600;
  localparam int CLK_NS       = 10;

  logic        clk;
  logic        rst_n;
  logic        serialInput;
  logic [7:0]  dataOut;
  logic        dataValid;
  logic        frameError;
  logic        busy;
  uart_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  logic [7:0] last_byte = 8'h00;
  time        last_valid_t = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_busy  = 1'b0;
  int         low_run = 0;
  int         last_low_run = 0;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serialInput (serialInput),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .frameError  (frameError),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_NS/2) clk = ~clk;

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (dataValid) begin
        valid_cnt    = valid_cnt + 1;
        last_byte    = dataOut;
        last_valid_t = $time;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_valid: got dataOut=%h, expected no strobe", dataOut);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dataOut !== e) begin
            errors = errors + 1;
            $display("FAIL byte: got %h expected %h", dataOut, e);
          end
        end
        if (prev_valid) begin
          errors = errors + 1;
          $display("FAIL valid_width: dataValid high 2 cycles, expected 1");
        end
      end
      if (frameError) begin
        ferr_cnt = ferr_cnt + 1;
        if (prev_ferr) begin
          errors = errors + 1;
          $display("FAIL ferr_width: frameError high 2 cycles, expected 1");
        end
      end
      if (dataValid || frameError) begin
        checks = checks + 1;
        if (dataValid && frameError) begin
          errors = errors + 1;
          $display("FAIL exclusive: dataValid=1 frameError=1, expected at most one");
        end
      end
      if (!busy) low_run = low_run + 1;
      if (busy && !prev_busy) last_low_run = low_run;
      if (busy) low_run = 0;
      prev_valid = dataValid;
      prev_ferr  = frameError;
      prev_busy  = busy;
    end else begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      prev_busy  = 1'b0;
      low_run    = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serialInput = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      serialInput = b[i];
      #(BIT_NS);
    end
    serialInput = stop_bit;
    #(BIT_NS);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    serialInput = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clks(3);
    checks = checks + 5;
    if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", dataOut); end
    if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dataValid); end
    if (frameError !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frameError); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg); end
  endtask

  task automatic test_single();
    int  v0, f0;
    time t0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    @(posedge clk);
    #(CLK_NS);
    exp_q.push_back(8'hAF);
    t0 = $time;
    send_frame(8'hAF, 1'b1);
    wait_clks(20);
    checks = checks + 6;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_count: got %0d pulses expected 1", valid_cnt - v0); end
    if (dataOut !== 8'hAF) begin errors++; $display("FAIL single_data: got %h expected af", dataOut); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL single_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
    // 9.5 bits = 81700 ns, plus synchronizer and register delay of a few clocks.
    if (last_valid_t < t0 + 81700 || last_valid_t > t0 + 81760) begin
      errors++; $display("FAIL single_latency: got %0t ns after start, expected 81700..81760", last_valid_t - t0);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    if (state_dbg !== IDLE) begin errors++; $display("FAIL single_state: got %0d expected IDLE", state_dbg); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h00);
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_clks(20);
    checks = checks + 3;
    if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 2", valid_cnt - v0); end
    if (dataOut !== 8'h00) begin errors++; $display("FAIL b2b_data: got %h expected 00", dataOut); end
    if (last_low_run < 1 || last_low_run >= CLKS_PER_BIT) begin
      errors++; $display("FAIL b2b_gap: busy low %0d cycles between frames, expected 1..%0d", last_low_run, CLKS_PER_BIT - 1);
    end
  endtask

  task automatic test_framing_error();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    #(2 * BIT_NS);
    checks = checks + 4;
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d pulses expected 1", ferr_cnt - f0); end
    if (valid_cnt != v0) begin errors++; $display("FAIL ferr_valid: got %0d pulses expected 0", valid_cnt - v0); end
    if (state_dbg !== BREAK_WAIT) begin errors++; $display("FAIL ferr_break_state: got %0d expected BREAK_WAIT", state_dbg); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
    serialInput = 1'b1;
    wait_clks(10);
    checks = checks + 4;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL ferr_idle_state: got %0d expected IDLE", state_dbg); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle_busy: got %b expected 0", busy); end
    if (dataOut !== 8'h00) begin errors++; $display("FAIL ferr_data: got %h expected 00", dataOut); end
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count_after: got %0d pulses expected 1", ferr_cnt - f0); end
    #(BIT_NS);
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    serialInput = 1'b0;
    #1000;
    checks = checks + 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    #1000;
    serialInput = 1'b1;
    wait_clks(600);
    checks = checks + 4;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected IDLE", state_dbg); end
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid: got %0d pulses expected 0", valid_cnt - v0); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_clks(20);
    checks = checks + 2;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL glitch_next_count: got %0d pulses expected 1", valid_cnt - v0); end
    if (dataOut !== 8'hC3) begin errors++; $display("FAIL glitch_next_data: got %h expected c3", dataOut); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         v0, f0;
    b = 8'hF0;
    serialInput = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      serialInput = b[i];
      #(BIT_NS);
    end
    serialInput = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #1;
    checks = checks + 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (state_dbg !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected IDLE", state_dbg); end
    if (dataOut !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", dataOut); end
    serialInput = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    #(BIT_NS);
    checks = checks + 1;
    if (valid_cnt != v0) begin errors++; $display("FAIL midrst_strobe: got %0d pulses expected 0", valid_cnt - v0); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_clks(20);
    checks = checks + 3;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL midrst_next_count: got %0d pulses expected 1", valid_cnt - v0); end
    if (dataOut !== 8'h12) begin errors++; $display("FAIL midrst_next_data: got %h expected 12", dataOut); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL midrst_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n       = 1'b0;
    serialInput = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_reset_mid_frame();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected bytes never received, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
